// File: rtl/calvera_mem_pkg.sv
// Shared types and helpers for the data-memory side of the core.
// The store buffer entry layout and the byte-mask overlap test live here.
package calvera_mem_pkg;

  localparam int SB_DEPTH = 8;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  bm;
    logic        io;
    logic [4:0]  rob;
  } sb_entry_t;

  function automatic logic bm_overlap(input logic [3:0] a, input logic [3:0] b);
    return |(a & b);
  endfunction

endpackage

// File: rtl/sb_conflict_cam.sv
// Load-vs-buffered-store conflict detector: every entry in [head, tail) is
// compared on word address and byte-mask overlap, then OR-reduced.
module sb_conflict_cam
  import calvera_mem_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTRW  = $clog2(DEPTH) + 1
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [PTRW-1:0]   head,
  input  logic [PTRW-1:0]   tail,
  input  logic [29:0]       address,
  input  logic [3:0]        bm,
  output logic              hit
);

  localparam int IDXW = PTRW - 1;

  logic [PTRW-1:0]  count;
  logic [DEPTH-1:0] match;

  assign count = tail - head;

  // A slot is live when its distance from head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [IDXW-1:0] off;
    logic            live;
    assign off      = IDXW'(i) - head[IDXW-1:0];
    assign live     = {1'b0, off} < count;
    assign match[i] = live && (entries[i].addr == address) && bm_overlap(entries[i].bm, bm);
  end

  assign hit = |match;

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: speculative stores wait for ROB commit, committed
// stores drain to memory over valid/ready, and loads are checked for overlap.
module store_buffer
  import calvera_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTRW  = $clog2(DEPTH) + 1
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        flush_i,
  input  logic        enqueue_en_i,
  input  logic [29:0] enqueue_address_i,
  input  logic [31:0] enqueue_data_i,
  input  logic [3:0]  enqueue_bm_i,
  input  logic        enqueue_io_i,
  input  logic [4:0]  enqueue_rob_i,
  output logic        enqueue_full_o,
  input  logic [29:0] conflict_address_i,
  input  logic [3:0]  conflict_bm_i,
  output logic        conflict_o,
  input  logic        commit_i,
  input  logic [4:0]  commit_rob_i,
  output logic        mem_req_vld_o,
  input  logic        mem_req_rdy_i,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_bm_o,
  output logic        mem_io_o,
  output logic        empty_o
);

  localparam int IDXW = PTRW - 1;

  // Handshake: memory takes the head entry on a cycle where mem_req_vld_o and
  // mem_req_rdy_i are both high; payload holds steady until then.
  sb_entry_t       entries [DEPTH];
  logic [PTRW-1:0] head, cmt, tail;
  logic [PTRW-1:0] cmt_next;
  logic            enq, drain;
  sb_entry_t       head_entry, new_entry;

  assign enqueue_full_o = (tail - head) == PTRW'(DEPTH);
  assign empty_o        = (head == tail);
  assign mem_req_vld_o  = (head != cmt);

  assign enq      = enqueue_en_i && !enqueue_full_o && !flush_i;
  assign drain    = mem_req_vld_o && mem_req_rdy_i;
  assign cmt_next = cmt + PTRW'(commit_i);

  assign new_entry = '{addr: enqueue_address_i, data: enqueue_data_i, bm: enqueue_bm_i,
                       io: enqueue_io_i, rob: enqueue_rob_i};

  assign head_entry = entries[head[IDXW-1:0]];
  assign mem_addr_o = head_entry.addr;
  assign mem_data_o = head_entry.data;
  assign mem_bm_o   = head_entry.bm;
  assign mem_io_o   = head_entry.io;

  // Flush rewinds tail to the post-commit boundary, so a same-cycle commit survives.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      head <= head + PTRW'(drain);
      cmt  <= cmt_next;
      tail <= flush_i ? cmt_next : tail + PTRW'(enq);
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (enq) entries[tail[IDXW-1:0]] <= new_entry;
  end

  sb_conflict_cam #(.DEPTH(DEPTH), .PTRW(PTRW)) u_cam (
    .entries (entries),
    .head    (head),
    .tail    (tail),
    .address (conflict_address_i),
    .bm      (conflict_bm_i),
    .hit     (conflict_o)
  );

  // The ROB may only retire a store that exists and carries the matching tag.
  a_commit_legal: assert property (@(posedge cpu_clock_i) disable iff (cpu_reset_i)
    commit_i |-> ((cmt != tail) && (entries[cmt[IDXW-1:0]].rob == commit_rob_i)));

endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the buffer's contents.
module tb_store_buffer;
  import calvera_mem_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        en = 1'b0;
  logic [29:0] e_addr = '0;
  logic [31:0] e_data = '0;
  logic [3:0]  e_bm = '0;
  logic        e_io = 1'b0;
  logic [4:0]  e_rob = '0;
  logic        full;
  logic [29:0] c_addr = '0;
  logic [3:0]  c_bm = '0;
  logic        conflict;
  logic        commit = 1'b0;
  logic [4:0]  commit_rob = '0;
  logic        vld;
  logic        rdy = 1'b0;
  logic [29:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_bm;
  logic        m_io;
  logic        empty;

  always #5 clk = ~clk;

  store_buffer dut (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush),
    .enqueue_en_i(en), .enqueue_address_i(e_addr), .enqueue_data_i(e_data),
    .enqueue_bm_i(e_bm), .enqueue_io_i(e_io), .enqueue_rob_i(e_rob),
    .enqueue_full_o(full), .conflict_address_i(c_addr), .conflict_bm_i(c_bm),
    .conflict_o(conflict), .commit_i(commit), .commit_rob_i(commit_rob),
    .mem_req_vld_o(vld), .mem_req_rdy_i(rdy), .mem_addr_o(m_addr),
    .mem_data_o(m_data), .mem_bm_o(m_bm), .mem_io_o(m_io), .empty_o(empty)
  );

  // Model: program-ordered queue; the first ncmt elements are committed.
  sb_entry_t   mq[$];
  int          ncmt = 0;
  logic [29:0] drain_log[$];
  int          total = 0;
  int          bad = 0;
  bit          checking = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_conflict();
    foreach (mq[k]) if (mq[k].addr == c_addr && (mq[k].bm & c_bm) != 4'b0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit full_pre;
    full_pre = (mq.size() == DEPTH);
    if (rst) begin
      mq.delete();
      ncmt = 0;
    end else begin
      if (ncmt > 0 && rdy) begin
        void'(mq.pop_front());
        ncmt--;
      end
      if (commit && ncmt < mq.size()) ncmt++;
      if (flush) begin
        while (mq.size() > ncmt) void'(mq.pop_back());
      end else if (en && !full_pre) begin
        mq.push_back('{addr: e_addr, data: e_data, bm: e_bm, io: e_io, rob: e_rob});
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("vld", vld, ncmt > 0);
      check("full", full, mq.size() == DEPTH);
      check("empty", empty, mq.size() == 0);
      check("conflict", conflict, model_conflict());
      if (ncmt > 0) begin
        check("mem_addr", m_addr, mq[0].addr);
        check("mem_data", m_data, mq[0].data);
        check("mem_bm", m_bm, mq[0].bm);
        check("mem_io", m_io, mq[0].io);
      end
      if (vld && rdy) drain_log.push_back(m_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [29:0] a, input logic [3:0] bm, input logic [4:0] rob);
    en = 1'b1; e_addr = a; e_data = $urandom(); e_bm = bm; e_io = a[29]; e_rob = rob;
    tick();
    en = 1'b0;
  endtask

  task automatic cmt_one();
    commit = 1'b1;
    commit_rob = mq[ncmt].rob;
    tick();
    commit = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    bit hold;
    bit accepted;
    int budget;

    // Reset state
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    checking = 1;
    check("reset_empty", empty, 1'b1);
    check("reset_full", full, 1'b0);
    check("reset_vld", vld, 1'b0);
    check("reset_conflict", conflict, 1'b0);

    // Three stores, commit each, drain in order
    enq(30'h10, 4'hf, 5'd1);
    enq(30'h11, 4'hf, 5'd2);
    enq(30'h12, 4'hf, 5'd3);
    rdy = 1'b1;
    check("vld_before_commit", vld, 1'b0);
    cmt_one();
    check("vld_after_commit", vld, 1'b1);
    check("first_addr", m_addr, 30'h10);
    cmt_one();
    cmt_one();
    idle(4);
    check("order_n", drain_log.size(), 3);
    if (drain_log.size() == 3) begin
      check("order_0", drain_log[0], 30'h10);
      check("order_1", drain_log[1], 30'h11);
      check("order_2", drain_log[2], 30'h12);
    end
    check("empty_after_drain", empty, 1'b1);

    // Fill, hold a payload while full, then free one slot
    drain_log.delete();
    rdy = 1'b0;
    for (int k = 0; k < DEPTH; k++) enq(30'h100 + 30'(k), 4'hf, 5'(k));
    check("full_after_fill", full, 1'b1);
    en = 1'b1; e_addr = 30'h1aa; e_data = 32'hcafe_f00d; e_bm = 4'h3; e_io = 1'b0; e_rob = 5'd20;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("full_hold", full, 1'b1);
    end
    cmt_one();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    budget = 0;
    while (full && budget < 4) begin tick(); budget++; end
    check("full_drop", full, 1'b0);
    tick();
    en = 1'b0;
    check("full_refill", full, 1'b1);
    rdy = 1'b1;
    while (ncmt < mq.size()) cmt_one();
    idle(DEPTH + 2);
    check("hold_n", drain_log.size(), 9);
    if (drain_log.size() == 9) check("hold_last", drain_log[8], 30'h1aa);

    // Flush with two committed, two speculative
    drain_log.delete();
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) enq(30'h200 + 30'(k), 4'hf, 5'(8 + k));
    cmt_one();
    cmt_one();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_full", full, 1'b0);
    check("flush_vld", vld, 1'b1);
    rdy = 1'b1;
    idle(4);
    enq(30'h2f0, 4'hf, 5'd12);
    cmt_one();
    idle(3);
    check("flush_n", drain_log.size(), 3);
    if (drain_log.size() == 3) begin
      check("flush_0", drain_log[0], 30'h200);
      check("flush_1", drain_log[1], 30'h201);
      check("flush_2", drain_log[2], 30'h2f0);
    end

    // Commit and flush together keep the committing entry
    drain_log.delete();
    enq(30'h300, 4'hf, 5'd13);
    commit = 1'b1; commit_rob = 5'd13; flush = 1'b1;
    tick();
    commit = 1'b0; flush = 1'b0;
    idle(3);
    check("cf_n", drain_log.size(), 1);
    if (drain_log.size() == 1) check("cf_addr", drain_log[0], 30'h300);
    check("cf_empty", empty, 1'b1);

    // Conflict address / mask cases
    rdy = 1'b0;
    enq(30'h20, 4'b0011, 5'd14);
    c_addr = 30'h20; c_bm = 4'b1100; #1;
    check("cam_disjoint", conflict, 1'b0);
    c_bm = 4'b0010; #1;
    check("cam_overlap", conflict, 1'b1);
    c_addr = 30'h21; c_bm = 4'b0011; #1;
    check("cam_other_word", conflict, 1'b0);

    // Backpressure: payload stable while not ready
    drain_log.delete();
    cmt_one();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_vld", vld, 1'b1);
      check("bp_addr", m_addr, 30'h20);
    end
    rdy = 1'b1;
    tick();
    check("bp_n", drain_log.size(), 1);
    check("bp_empty", empty, 1'b1);

    // Random traffic with one mid-run reset
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst = 1'b1; en = 1'b0; commit = 1'b0; flush = 1'b0; hold = 0;
        tick();
        rst = 1'b0;
        continue;
      end
      if (!hold) begin
        en = ($urandom_range(0, 2) != 0);
        e_addr = 30'h20 + 30'($urandom_range(0, 7));
        e_data = $urandom();
        e_bm = 4'($urandom_range(1, 15));
        e_io = 1'($urandom_range(0, 1));
        e_rob = 5'($urandom_range(0, 31));
      end
      commit = (ncmt < mq.size()) && ($urandom_range(0, 1) != 0);
      commit_rob = commit ? mq[ncmt].rob : 5'd0;
      flush = ($urandom_range(0, 31) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      c_addr = 30'h20 + 30'($urandom_range(0, 7));
      c_bm = 4'($urandom_range(0, 15));
      accepted = en && (mq.size() < DEPTH) && !flush;
      tick();
      hold = en && !accepted && !flush;
    end

    // Drain everything out within a bounded number of cycles
    en = 1'b0; flush = 1'b0; rdy = 1'b1;
    budget = 0;
    while (mq.size() > 0 && budget < 200) begin
      commit = (ncmt < mq.size());
      commit_rob = commit ? mq[ncmt].rob : 5'd0;
      tick();
      budget++;
    end
    commit = 1'b0;
    check("final_drain", mq.size(), 0);
    tick();
    check("final_empty", empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
